// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit:
// opcode groups, ROM0 control-flow indices and FSM states.
package instruction_fetch_pkg;

    localparam logic [23:0] GRP_800000 = 24'h800000;
    localparam logic [23:0] GRP_400000 = 24'h400000;
    localparam logic [23:0] GRP_200000 = 24'h200000;
    localparam logic [23:0] GRP_100000 = 24'h100000;
    localparam logic [23:0] GRP_080000 = 24'h080000;

    typedef enum logic [2:0] {
        OP_JMP = 3'd0,
        OP_JZE = 3'd1,
        OP_JNE = 3'd2,
        OP_JCY = 3'd3,
        OP_RET = 3'd4,
        OP_BSR = 3'd5,
        OP_MOM = 3'd6
    } rom0_op_e;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_RESOLVE
    } if_state_e;

    // hi = IR[23:12]; group 0x800000 with ROM0 index 0..5
    function automatic logic is_ctrl(input logic [11:0] hi);
        return (hi[11:7] == GRP_800000[23:19]) && (hi[6:0] <= 7'd5);
    endfunction

endpackage

// File: rtl/instruction_fetch_return_stack.sv
// Return-address stack for BSR/RET; pushes when full and pops
// when empty are ignored, the caller flags the error.
module return_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [11:0] data_i,
    output logic [11:0] data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] sp_q;
    logic [PW-1:0] sp_d;
    logic [11:0]   mem_q [DEPTH];

    assign full_o  = (sp_q == PW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign data_o  = mem_q[IW'(sp_q - 1'b1)];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[IW'(sp_q)] <= data_i;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: reads program memory, hands IR to the
// decoder and resolves jumps, branches and subroutine calls.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] pmem_addr,
    output logic        pmem_rd,
    input  logic [23:0] pmem_data,
    input  logic        pmem_valid,
    output logic [23:0] IR,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        zero_flag,
    input  logic        carry_flag,
    input  logic        flags_valid,
    output logic [11:0] pc,
    output logic        stk_err
);

    if_state_e   state_q;
    logic [11:0] pc_q;
    logic [23:0] ir_q;
    logic        ir_valid_q;
    logic        rd_q;
    logic [11:0] addr_q;
    logic        err_q;

    logic [11:0] pc_inc;
    logic [11:0] tgt;
    logic [11:0] res_pc_d;
    logic        resolve;
    logic        push;
    logic        pop;
    logic        err_set;
    logic [11:0] stk_top;
    logic        stk_full;
    logic        stk_empty;
    rom0_op_e    op;

    assign pc_inc  = pc_q + 12'd1;
    assign tgt     = ir_q[11:0];
    assign op      = rom0_op_e'(ir_q[14:12]);
    assign resolve = (state_q == ST_RESOLVE) && flags_valid;

    always_comb begin
        res_pc_d = pc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        err_set  = 1'b0;
        case (op)
            OP_JMP: res_pc_d = tgt;
            OP_JZE: res_pc_d = zero_flag ? tgt : pc_inc;
            OP_JNE: res_pc_d = zero_flag ? pc_inc : tgt;
            OP_JCY: res_pc_d = carry_flag ? tgt : pc_inc;
            OP_RET: begin
                if (stk_empty) begin
                    err_set = resolve;
                end else begin
                    res_pc_d = stk_top;
                    pop      = resolve;
                end
            end
            OP_BSR: begin
                res_pc_d = tgt;
                err_set  = resolve && stk_full;
                push     = resolve && !stk_full;
            end
            default: res_pc_d = pc_inc;
        endcase
    end

    return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .data_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    rd_q    <= 1'b1;
                    addr_q  <= pc_q;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    rd_q <= 1'b0;
                    if (pmem_valid) begin
                        ir_q       <= pmem_data;
                        ir_valid_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ir_ready) begin
                        ir_valid_q <= 1'b0;
                        if (is_ctrl(ir_q[23:12])) begin
                            state_q <= ST_RESOLVE;
                        end else begin
                            pc_q    <= pc_inc;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_RESOLVE: begin
                    if (flags_valid) begin
                        pc_q    <= res_pc_d;
                        state_q <= ST_FETCH;
                        if (err_set) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign pmem_addr = addr_q;
    assign pmem_rd   = rd_q;
    assign IR        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign pc        = pc_q;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus
// a randomized program checked against an architectural model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] pmem_addr;
    logic        pmem_rd;
    logic [23:0] pmem_data = '0;
    logic        pmem_valid = 1'b0;
    logic [23:0] IR;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        zero_flag = 1'b0;
    logic        carry_flag = 1'b0;
    logic        flags_valid = 1'b0;
    logic [11:0] pc;
    logic        stk_err;

    instruction_fetch #(
        .STACK_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pmem_addr   (pmem_addr),
        .pmem_rd     (pmem_rd),
        .pmem_data   (pmem_data),
        .pmem_valid  (pmem_valid),
        .IR          (IR),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .flags_valid (flags_valid),
        .pc          (pc),
        .stk_err     (stk_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [23:0] mem [4096];
    logic [11:0] m_pc;
    logic [11:0] stk [$];
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_is_cf(input logic [23:0] w);
        return (w[23:19] == 5'b10000) && (w[19:12] <= 8'd5);
    endfunction

    task automatic model_reset;
        m_pc = 12'h000;
        stk.delete();
        m_err = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'h0);
        chk({tag, "_rd"}, 32'(pmem_rd), 32'h0);
        chk({tag, "_addr"}, 32'(pmem_addr), 32'h0);
        chk({tag, "_ir"}, 32'(IR), 32'h0);
        chk({tag, "_irv"}, 32'(ir_valid), 32'h0);
        chk({tag, "_err"}, 32'(stk_err), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_reset_vals(tag);
        tick;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_instr(input int lat, input int rdy, input int fd,
                             input logic zf, input logic cf);
        logic [23:0] w;
        logic [11:0] x;
        logic [11:0] inc;
        int n;
        n = 0;
        while (pmem_rd !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("rd_seen", 32'(pmem_rd), 32'h1);
        chk("fetch_addr", 32'(pmem_addr), 32'(m_pc));
        w = mem[m_pc];
        repeat (lat) tick;
        pmem_data = w;
        pmem_valid = 1'b1;
        tick;
        pmem_valid = 1'b0;
        pmem_data = 24'($urandom);
        chk("ir_valid_set", 32'(ir_valid), 32'h1);
        chk("ir_value", 32'(IR), 32'(w));
        chk("rd_single", 32'(pmem_rd), 32'h0);
        for (int i = 0; i < rdy; i++) begin
            tick;
            chk("hold_irv", 32'(ir_valid), 32'h1);
            chk("hold_ir", 32'(IR), 32'(w));
            chk("hold_rd", 32'(pmem_rd), 32'h0);
        end
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0;
        chk("ir_consumed", 32'(ir_valid), 32'h0);
        inc = m_pc + 12'd1;
        if (!model_is_cf(w)) begin
            m_pc = inc;
        end else begin
            for (int i = 0; i < fd; i++) begin
                zero_flag = 1'($urandom);
                carry_flag = 1'($urandom);
                tick;
                chk("resolve_no_rd", 32'(pmem_rd), 32'h0);
                chk("resolve_pc", 32'(pc), 32'(m_pc));
            end
            zero_flag = zf;
            carry_flag = cf;
            flags_valid = 1'b1;
            tick;
            flags_valid = 1'b0;
            x = w[11:0];
            case (w[19:12])
                8'd0: m_pc = x;
                8'd1: m_pc = zf ? x : inc;
                8'd2: m_pc = zf ? inc : x;
                8'd3: m_pc = cf ? x : inc;
                8'd4: begin
                    if (stk.size() == 0) begin
                        m_err = 1'b1;
                        m_pc = inc;
                    end else begin
                        m_pc = stk.pop_back();
                    end
                end
                default: begin
                    if (stk.size() == 8) m_err = 1'b1;
                    else stk.push_back(inc);
                    m_pc = x;
                end
            endcase
        end
        chk("pc_after", 32'(pc), 32'(m_pc));
        chk("stk_err", 32'(stk_err), 32'(m_err));
    endtask

    initial begin
        logic [23:0] w;
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 24'h000000;
        model_reset();

        #1;
        do_reset("por");

        // reset release, sequential word, then fetch at 0x001
        mem[12'h000] = 24'h400001;
        run_instr(1, 0, 0, 1'b0, 1'b0);

        // JZE taken / not taken with late flags
        mem[12'h001] = 24'h801123;
        run_instr(1, 0, 4, 1'b1, 1'b0);
        mem[12'h123] = 24'h801456;
        run_instr(1, 0, 4, 1'b0, 1'b0);

        // JMP to 0x010, BSR 0x200, RET back to 0x011
        mem[12'h124] = 24'h800010;
        run_instr(1, 0, 0, 1'b0, 1'b0);
        mem[12'h010] = 24'h805200;
        run_instr(1, 0, 1, 1'b0, 1'b0);
        mem[12'h200] = 24'h804000;
        run_instr(1, 0, 2, 1'b0, 1'b0);
        chk("ret_pc", 32'(pc), 32'h011);
        chk("ret_err", 32'(stk_err), 32'h0);

        // decoder stall at 0xFFF, then wrap to 0x000
        mem[12'h011] = 24'h800FFF;
        run_instr(1, 0, 0, 1'b0, 1'b0);
        mem[12'hFFF] = 24'h123456;
        run_instr(1, 5, 0, 1'b0, 1'b0);
        chk("wrap_pc", 32'(pc), 32'h000);
        run_instr(0, 0, 0, 1'b0, 1'b0);

        // nine nested calls overflow an 8-deep stack
        do_reset("rst_bsr");
        for (int k = 0; k < 9; k++) begin
            mem[12'(k * 256)] = 24'h805000 | 24'(((k + 1) * 256) & 12'hFFF);
        end
        for (int k = 0; k < 9; k++) run_instr(1, 0, 0, 1'b0, 1'b0);
        chk("bsr9_err", 32'(stk_err), 32'h1);
        chk("bsr9_pc", 32'(pc), 32'h900);

        // RET with empty stack
        do_reset("rst_ret");
        mem[12'h000] = 24'h804000;
        mem[12'h001] = 24'h000000;
        run_instr(1, 0, 0, 1'b0, 1'b0);
        chk("ret_empty_err", 32'(stk_err), 32'h1);
        run_instr(1, 0, 0, 1'b0, 1'b0);

        // reset pulsed during WAIT, late pmem_valid ignored
        do_reset("rst_wait");
        mem[12'h000] = 24'h000005;
        n = 0;
        while (pmem_rd !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("wait_rd", 32'(pmem_rd), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async");
        tick;
        rst = 1'b0;
        pmem_data = 24'h804000;
        pmem_valid = 1'b1;
        tick;
        pmem_valid = 1'b0;
        chk("late_valid_irv", 32'(ir_valid), 32'h0);
        chk("resume_rd", 32'(pmem_rd), 32'h1);
        chk("resume_addr", 32'(pmem_addr), 32'h000);
        model_reset();
        run_instr(1, 0, 0, 1'b0, 1'b0);

        // randomized program
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(3, 0))
                0, 1: w = 24'($urandom) & 24'h3FFFFF;
                2: w = {5'b10000, 4'b0000, 3'($urandom_range(7, 0)),
                        12'($urandom)};
                default: w = 24'($urandom);
            endcase
            mem[m_pc] = w;
            run_instr(int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                      int'($urandom_range(3, 0)), 1'($urandom),
                      1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, giving the number of return-stack entries.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port pmem_addr, output, 12 bits: program memory word address.
REQ-005 SHALL have port pmem_rd, output, 1 bit: read request, one-cycle pulse.
REQ-006 SHALL have port pmem_data, input, 24 bits: instruction word returned by memory.
REQ-007 SHALL have port pmem_valid, input, 1 bit: pmem_data valid this cycle.
REQ-008 SHALL have port IR, output, 24 bits: instruction presented to the microinstruction decoder.
REQ-009 SHALL have port ir_valid, output, 1 bit: IR holds an unconsumed instruction.
REQ-010 SHALL have port ir_ready, input, 1 bit: decoder accepts IR; transfer occurs when ir_valid and ir_ready are both high at a clock edge.
REQ-011 SHALL have ports zero_flag and carry_flag, inputs, 1 bit each: datapath status flags.
REQ-012 SHALL have port flags_valid, input, 1 bit: flags reflect all previously issued instructions.
REQ-013 SHALL have port pc, output, 12 bits: current program counter.
REQ-014 SHALL have port stk_err, output, 1 bit: sticky return-stack overflow/underflow.

Function
REQ-015 SHALL use a state machine with states FETCH, WAIT, ISSUE and RESOLVE; all outputs SHALL be registered.
REQ-016 FETCH: pmem_rd=1 and pmem_addr=pc for exactly one cycle, then go to WAIT.
REQ-017 WAIT: pmem_rd=0; on pmem_valid, IR<=pmem_data, ir_valid<=1, go to ISSUE; pmem_valid in any other state SHALL be ignored.
REQ-018 ISSUE: hold IR and ir_valid stable until ir_ready. On transfer, ir_valid<=0; if the instruction is control-flow, go to RESOLVE; otherwise pc<=pc+1 and go to FETCH.
REQ-019 An instruction is control-flow when IR[23:19]=5'b10000 (group 0x800000) and IR[19:12] is 0..5; index 6/7 (MOM) and all other groups SHALL be sequential.
REQ-020 RESOLVE: wait for flags_valid, then compute the next pc from target X=IR[11:0] and go to FETCH. JMP(0): X. JZE(1): X if zero_flag else pc+1. JNE(2): X if !zero_flag else pc+1. JCY(3): X if carry_flag else pc+1. BSR(5): push pc+1, pc<=X. RET(4): pop into pc.
REQ-021 Minimum throughput: 3 cycles per sequential instruction (FETCH, WAIT, ISSUE with pmem_valid and ir_ready immediate); RESOLVE adds at least 1 cycle.
REQ-022 pc+1 SHALL wrap from 0xFFF to 0x000.
REQ-023 BSR with the stack full: drop the push, set stk_err, still jump to X.
REQ-024 RET with the stack empty: set stk_err, pc<=pc+1.
REQ-025 stk_err SHALL clear only on rst.

Reset
REQ-026 While rst is high: state=FETCH, pc=0x000, IR=0, ir_valid=0, pmem_rd=0, pmem_addr=0, stack empty, stk_err=0.
REQ-027 rst asserted mid-operation SHALL abort any outstanding read or issue immediately; the first cycle after release SHALL be FETCH at address 0x000.

Structure
REQ-028 A shared package SHALL hold the group constants (0x800000, 0x400000, 0x200000, 0x100000, 0x080000), the ROM0 opcode indices JMP..MOM, and the state enumeration.
REQ-029 The return stack SHALL be a sub-module, return_stack: push/pop/full/empty, depth STACK_DEPTH, 12-bit entries.

Verification
REQ-030 Reset release with memory word 0x400001 at 0, 1-cycle memory latency, ir_ready=1 -> pmem_rd pulses with addr 0x000; IR=0x400001 with ir_valid high for 1 cycle; pmem_rd next pulses with addr 0x001.
REQ-031 IR 0x801123 (JZE 0x123) with zero_flag=1, flags_valid delayed 4 cycles -> no pmem_rd until flags_valid; next fetch at 0x123. Repeat with zero_flag=0 -> next fetch at pc+1.
REQ-032 BSR 0x805200 at pc 0x010, then RET at 0x200 -> fetches at 0x200, then 0x011; stk_err=0.
REQ-033 Nine nested BSRs with STACK_DEPTH=8 -> stk_err=1 after the ninth; the ninth jump is still taken. Separately, RET from reset -> stk_err=1 and the next fetch is at 0x001.
REQ-034 ir_ready held low 5 cycles -> IR/ir_valid stable throughout, no pmem_rd; sequential instruction at pc 0xFFF -> next fetch at 0x000.
REQ-035 rst pulsed during WAIT -> outputs reach reset values without a clock edge; a late pmem_valid is ignored; fetch resumes at 0x000.
